// File: rtl/psum_col_fifo.sv
// Per-column psum FIFOs below the MAC array bottom row.
// Columns fill independently; all columns pop together as one aligned row.
module psum_col_fifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   o_overflow,
  output logic                   o_underflow
);

  localparam int aw = $clog2(depth);

  typedef logic [aw:0] ptr_t;

  ptr_t wptr_q [col];
  ptr_t wptr_d [col];
  ptr_t rptr_q [col];
  ptr_t rptr_d [col];

  logic [psum_bw-1:0] mem_q [col][depth];

  logic [col-1:0] empty;
  logic [col-1:0] full;
  logic [col-1:0] push;
  logic           pop;
  logic           overflow_q;
  logic           overflow_d;
  logic           underflow_q;
  logic           underflow_d;

  always_comb begin
    for (int c = 0; c < col; c++) begin
      empty[c] = (wptr_q[c] == rptr_q[c]);
      full[c]  = (wptr_q[c][aw-1:0] == rptr_q[c][aw-1:0])
              && (wptr_q[c][aw] != rptr_q[c][aw]);
    end

    o_valid = ~|empty;
    o_full  = |full;
    o_ready = ~o_full;

    // a pop in the same cycle frees a slot in a full column
    pop  = rd & o_valid;
    push = wr & (~full | {col{pop}});

    for (int c = 0; c < col; c++) begin
      wptr_d[c] = wptr_q[c] + ptr_t'(push[c]);
      rptr_d[c] = rptr_q[c] + ptr_t'(pop);
    end

    overflow_d  = overflow_q | (|(wr & full & ~{col{pop}}));
    underflow_d = underflow_q | (rd & ~o_valid);

    out = '0;
    if (o_valid) begin
      for (int c = 0; c < col; c++) begin
        out[c*psum_bw +: psum_bw] = mem_q[c][rptr_q[c][aw-1:0]];
      end
    end

    o_overflow  = overflow_q;
    o_underflow = underflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      for (int c = 0; c < col; c++) begin
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // storage is never cleared; reset only blocks writes
  always_ff @(posedge clk) begin
    for (int c = 0; c < col; c++) begin
      if (!reset && push[c]) begin
        mem_q[c][wptr_q[c][aw-1:0]] <= in[c*psum_bw +: psum_bw];
      end
    end
  end

endmodule
